uart_tx_sched: RTL and testbench

Transmit scheduler that shares the single `uart_tx` instance between two byte sources: CPU stores to the UART address, and an auxiliary hardware source such as a debug/status message generator. Bytes are arbitrated into a small FIFO and issued to `uart_tx` one at a time, honouring its busy handshake. The block sits in the top level between the store-decode logic (`is_data && set_uart_tx`) and `uart_tx`. CPU stores cannot stall, so CPU bytes have priority; overflow is flagged, never blocked.

---
 rtl/uart_tx_sched.sv | 127 ++++++++++++
 tb/tb_uart_tx_sched.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Shares one uart_tx between CPU stores (priority, never stalled) and an aux source through a small FIFO.
// Latency: push counted next cycle, empty-to-tx_en two cycles; backpressure: aux via aux_ready, CPU bytes dropped when full (sticky overflow).
module uart_tx_sched #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_valid,
    input  logic [7:0]            cpu_data,
    input  logic                  aux_valid,
    input  logic [7:0]            aux_data,
    output logic                  aux_ready,
    output logic                  tx_en,
    output logic [7:0]            tx_data,
    input  logic                  tx_busy,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    input  logic                  clr_overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t                state;
    logic [1:0]            tmo_cnt;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic [7:0]            push_data;

    // Full/empty come from the registered level, so a same-cycle pop never frees a slot early.
    assign full      = (level == FULL_LEVEL);
    assign empty     = (level == '0);
    assign aux_ready = !full && !cpu_valid;
    assign drop      = cpu_valid && full;
    assign push      = (cpu_valid || aux_valid) && !full;
    assign push_data = cpu_valid ? cpu_data : aux_data;
    assign pop       = (state == IDLE) && !empty && !tx_busy;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tmo_cnt <= 2'd0;
            tx_en   <= 1'b0;
            tx_data <= 8'h00;
        end else begin
            tx_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_en   <= 1'b1;
                        tx_data <= mem[rd_ptr];
                        tmo_cnt <= 2'd0;
                        state   <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    // No busy within the timeout means uart_tx missed the start pulse; move on.
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (tmo_cnt == 2'd2) begin
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 2'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: table-driven arbitration/overflow vectors plus hand-written issue sequences,
// with a scoreboard of accepted bytes checked against every tx_en.
module tb_uart_tx_sched;
    localparam int DL    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_valid;
    logic [7:0]    cpu_data;
    logic          aux_valid;
    logic [7:0]    aux_data;
    logic          aux_ready;
    logic          tx_en;
    logic [7:0]    tx_data;
    logic          tx_busy;
    logic [DL:0]   level;
    logic          overflow;
    logic          clr_overflow;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    int         en_cyc[$];
    int         m_lvl = 0;
    int         n_issued = 0;
    int         cyc = 0;
    int         busy_len = 6;
    bit         busy_hold = 1'b0;
    bit         busy_none = 1'b0;
    int         busy_cnt = 0;
    bit         start_pending = 1'b0;
    bit         prev_en = 1'b0;

    typedef struct {
        bit         cv;
        logic [7:0] cd;
        bit         av;
        logic [7:0] ad;
        bit         clr;
        bit         rdy;
        int         lvl;
        bit         ovf;
    } vec_t;
    vec_t tbl[9];

    uart_tx_sched #(.DEPTH_LOG2(DL)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_valid    (cpu_valid),
        .cpu_data     (cpu_data),
        .aux_valid    (aux_valid),
        .aux_data     (aux_data),
        .aux_ready    (aux_ready),
        .tx_en        (tx_en),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .level        (level),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
        end
    endtask

    // uart_tx model plus scoreboard consumer, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst) begin
            exp_q.delete();
            m_lvl         = 0;
            busy_cnt      = 0;
            start_pending = 1'b0;
            prev_en       = 1'b0;
        end else begin
            if (tx_en) begin
                check("double_tx_en", prev_en, 1'b0);
                if (exp_q.size() == 0) begin
                    check("unexpected_tx_en", 1, 0);
                end else begin
                    check("tx_data_order", tx_data, exp_q.pop_front());
                end
                m_lvl--;
                n_issued++;
                en_cyc.push_back(cyc);
                if (!busy_none) start_pending = 1'b1;
            end else if (start_pending) begin
                busy_cnt      = busy_len;
                start_pending = 1'b0;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
            prev_en = tx_en;
        end
        tx_busy = busy_hold || (busy_cnt > 0);
    end

    // Drives one cycle of inputs at the falling edge and records what the bench expects to be accepted.
    task automatic drive(input bit cv, input logic [7:0] cd, input bit av, input logic [7:0] ad,
                         input bit clr, output bit exp_rdy);
        @(negedge clk);
        cpu_valid    = cv;
        cpu_data     = cd;
        aux_valid    = av;
        aux_data     = ad;
        clr_overflow = clr;
        #1;
        exp_rdy = !cv && (m_lvl < DEPTH);
        if (cv && m_lvl < DEPTH) begin
            exp_q.push_back(cd);
            m_lvl++;
        end else if (av && exp_rdy) begin
            exp_q.push_back(ad);
            m_lvl++;
        end
    endtask

    task automatic wait_issued(input int target, input int budget, input string name);
        int k = 0;
        while (n_issued < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        #2;
        check(name, n_issued, target);
    endtask

    task automatic settle(input int budget);
        int k = 0;
        while (tx_busy && k < budget) begin
            @(posedge clk);
            k++;
        end
        repeat (4) @(posedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit r;
        int base;
        int spins;

        rst = 1'b1; cpu_valid = 1'b0; cpu_data = 8'h00; aux_valid = 1'b0;
        aux_data = 8'h00; clr_overflow = 1'b0; tx_busy = 1'b0;

        tbl[0] = '{1'b1, 8'hA0, 1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b0};
        tbl[1] = '{1'b0, 8'h00, 1'b1, 8'hA1, 1'b0, 1'b1, 2, 1'b0};
        tbl[2] = '{1'b1, 8'hA2, 1'b1, 8'hA3, 1'b0, 1'b0, 3, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 8'hA3, 1'b0, 1'b1, 4, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 8'hA4, 1'b0, 1'b0, 4, 1'b0};
        tbl[5] = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 4, 1'b1};
        tbl[6] = '{1'b1, 8'hA6, 1'b0, 8'h00, 1'b1, 1'b0, 4, 1'b1};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 4, 1'b0};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 4, 1'b0};
        // Rows 7/8: aux_valid low, so aux_ready is still !full -> 0.
        tbl[7].rdy = 1'b0;
        tbl[8].rdy = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_level", level, 0);
        check("rst_tx_en", tx_en, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_overflow", overflow, 0);
        check("rst_aux_ready", aux_ready, 1);

        // Single CPU byte: counted next cycle, issued two cycles after the store.
        drive(1'b1, 8'h41, 1'b0, 8'h00, 1'b0, r);
        @(posedge clk); #2;
        check("single_level1", level, 1);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, r);
        @(posedge clk); #2;
        check("single_tx_en", tx_en, 1);
        check("single_tx_data", tx_data, 8'h41);
        check("single_level0", level, 0);
        @(posedge clk); #2;
        check("single_tx_en_pulse", tx_en, 0);
        check("single_overflow", overflow, 0);
        settle(200);

        // Arbitration / overflow table with uart_tx held busy so nothing drains.
        busy_hold = 1'b1;
        @(posedge clk);
        base = n_issued;
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].cv, tbl[i].cd, tbl[i].av, tbl[i].ad, tbl[i].clr, r);
            check($sformatf("tbl%0d_aux_ready", i), aux_ready, tbl[i].rdy);
            @(posedge clk); #2;
            check($sformatf("tbl%0d_level", i), level, tbl[i].lvl);
            check($sformatf("tbl%0d_overflow", i), overflow, tbl[i].ovf);
        end
        busy_hold = 1'b0;
        wait_issued(base + 4, 400, "ovf_drain_count");
        settle(200);
        check("ovf_queue_empty", exp_q.size(), 0);
        check("ovf_level0", level, 0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("spacing%0d_min", i),
                  (en_cyc[base + i + 1] - en_cyc[base + i]) >= busy_len + 2, 1);
        end

        // Simultaneous sources: CPU wins, aux follows a cycle later.
        base = n_issued;
        drive(1'b1, 8'h10, 1'b1, 8'h20, 1'b0, r);
        check("simul_aux_ready0", aux_ready, 0);
        drive(1'b0, 8'h00, 1'b1, 8'h20, 1'b0, r);
        check("simul_aux_ready1", aux_ready, 1);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, r);
        wait_issued(base + 2, 200, "simul_count");
        settle(200);

        // Wrap-around: 10 aux bytes with random gaps against a 20-cycle busy.
        busy_len = 20;
        base = n_issued;
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 3)) drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, r);
            spins = 0;
            do begin
                drive(1'b0, 8'h00, 1'b1, i[7:0], 1'b0, r);
                check("wrap_aux_ready", aux_ready, r);
                check("wrap_level_max", level <= DEPTH, 1);
                spins++;
            end while (!r && spins < 500);
        end
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, r);
        wait_issued(base + 10, 2000, "wrap_count");
        settle(200);
        check("wrap_queue_empty", exp_q.size(), 0);

        // Lost handshake: no busy at all; timeout returns to IDLE and the next byte follows.
        busy_none = 1'b1;
        base = n_issued;
        drive(1'b1, 8'h61, 1'b0, 8'h00, 1'b0, r);
        drive(1'b1, 8'h62, 1'b0, 8'h00, 1'b0, r);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, r);
        wait_issued(base + 2, 100, "lost_count");
        if (n_issued >= base + 2) begin
            check("lost_spacing", en_cyc[base + 1] - en_cyc[base], 4);
        end
        busy_none = 1'b0;
        settle(200);

        // Reset while the first of three bytes is in flight.
        busy_len = 30;
        base = n_issued;
        drive(1'b1, 8'h51, 1'b0, 8'h00, 1'b0, r);
        drive(1'b1, 8'h52, 1'b0, 8'h00, 1'b0, r);
        drive(1'b1, 8'h53, 1'b0, 8'h00, 1'b0, r);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, r);
        wait_issued(base + 1, 50, "rstmid_first_issue");
        repeat (5) @(posedge clk);
        #2;
        check("rstmid_level_before", level, 2);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #2;
        check("rstmid_level", level, 0);
        check("rstmid_tx_en", tx_en, 0);
        check("rstmid_overflow", overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        base = n_issued;
        repeat (60) @(posedge clk);
        #2;
        check("rstmid_no_issue", n_issued, base);
        check("rstmid_level_after", level, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
